// File: rtl/min_max_operand_sequencer.sv
// ---------------------------------------------------------------------------
// min_max_operand_sequencer
//
// Streaming front end for the max/min calculator HLSM. Three operands arrive
// one at a time on a valid/ready stream (order x, y, z) and are presented to
// the calculator in parallel. The block then runs the calculator's level
// sensitive start/done/ack handshake and hands max/min downstream on a
// valid/ready result port.
//
// Optional build macro: MINMAX_TIMEOUT_EN
//   When defined, a WAIT_DONE watchdog of TIMEOUT_CYCLES cycles is added. On
//   expiry the calculator is acked, no result is produced and the sticky
//   timeout_err flag is raised until the next operand-0 accept.
//   When undefined, WAIT_DONE waits forever and timeout_err is tied to 0.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   op_data      serial operand (x, then y, then z)
//   op_valid     op_data valid
//   op_ready     sequencer can accept an operand (LOAD only)
//   res_max      captured maximum
//   res_min      captured minimum
//   res_valid    result available (RESULT only)
//   res_ready    downstream accepts result
//   calc_x/y/z   operands to calculator, held stable until rewritten
//   calc_start   one-cycle start pulse
//   calc_ack     one-cycle acknowledge pulse
//   calc_done    calculator DONE_S indication
//   calc_max     calculator maximum
//   calc_min     calculator minimum
//   busy         high in every state except LOAD
//   timeout_err  sticky watchdog flag
// ---------------------------------------------------------------------------
module min_max_operand_sequencer #(
    parameter int WIDTH          = 3,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] op_data,
    input  logic             op_valid,
    output logic             op_ready,
    output logic [WIDTH-1:0] res_max,
    output logic [WIDTH-1:0] res_min,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] calc_x,
    output logic [WIDTH-1:0] calc_y,
    output logic [WIDTH-1:0] calc_z,
    output logic             calc_start,
    output logic             calc_ack,
    input  logic             calc_done,
    input  logic [WIDTH-1:0] calc_max,
    input  logic [WIDTH-1:0] calc_min,
    output logic             busy,
    output logic             timeout_err
);

    typedef enum logic [2:0] {
        LOAD,
        START,
        WAIT_DONE,
        ACK,
        RESULT
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [WIDTH-1:0] calcX_q, calcX_d;
    logic [WIDTH-1:0] calcY_q, calcY_d;
    logic [WIDTH-1:0] calcZ_q, calcZ_d;
    logic [WIDTH-1:0] resMax_q, resMax_d;
    logic [WIDTH-1:0] resMin_q, resMin_d;

`ifdef MINMAX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] toCnt_q, toCnt_d;
    logic             toErr_q, toErr_d;
`endif

    // State and datapath registers; everything clears asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= LOAD;
            idx_q    <= 2'd0;
            calcX_q  <= '0;
            calcY_q  <= '0;
            calcZ_q  <= '0;
            resMax_q <= '0;
            resMin_q <= '0;
`ifdef MINMAX_TIMEOUT_EN
            toCnt_q  <= '0;
            toErr_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            calcX_q  <= calcX_d;
            calcY_q  <= calcY_d;
            calcZ_q  <= calcZ_d;
            resMax_q <= resMax_d;
            resMin_q <= resMin_d;
`ifdef MINMAX_TIMEOUT_EN
            toCnt_q  <= toCnt_d;
            toErr_q  <= toErr_d;
`endif
        end
    end

    // Next-state logic. Operand registers are only written in LOAD, so the
    // calculator sees stable x/y/z for the whole handshake.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        calcX_d  = calcX_q;
        calcY_d  = calcY_q;
        calcZ_d  = calcZ_q;
        resMax_d = resMax_q;
        resMin_d = resMin_q;
`ifdef MINMAX_TIMEOUT_EN
        toCnt_d  = toCnt_q;
        toErr_d  = toErr_q;
`endif
        case (state_q)
            LOAD: begin
                if (op_valid) begin
                    case (idx_q)
                        2'd0: begin
                            calcX_d = op_data;
                            idx_d   = 2'd1;
`ifdef MINMAX_TIMEOUT_EN
                            toErr_d = 1'b0;
`endif
                        end
                        2'd1: begin
                            calcY_d = op_data;
                            idx_d   = 2'd2;
                        end
                        default: begin
                            calcZ_d = op_data;
                            idx_d   = 2'd0;
                            state_d = START;
                        end
                    endcase
                end
            end
            START: begin
                state_d = WAIT_DONE;
`ifdef MINMAX_TIMEOUT_EN
                toCnt_d = '0;
`endif
            end
            WAIT_DONE: begin
                if (calc_done) begin
                    resMax_d = calc_max;
                    resMin_d = calc_min;
                    state_d  = ACK;
                end
`ifdef MINMAX_TIMEOUT_EN
                // The count reaching the limit on this edge means this is
                // the last permitted WAIT_DONE cycle.
                else if (toCnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    toErr_d = 1'b1;
                    state_d = ACK;
                end else begin
                    toCnt_d = toCnt_q + 1'b1;
                end
`endif
            end
            ACK: begin
`ifdef MINMAX_TIMEOUT_EN
                // A set flag here can only come from this episode, because
                // it is cleared when operand 0 of the triple was accepted.
                state_d = toErr_q ? LOAD : RESULT;
`else
                state_d = RESULT;
`endif
            end
            RESULT: begin
                if (res_ready) begin
                    state_d = LOAD;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    assign op_ready   = (state_q == LOAD);
    assign calc_start = (state_q == START);
    assign calc_ack   = (state_q == ACK);
    assign res_valid  = (state_q == RESULT);
    assign busy       = (state_q != LOAD);
    assign calc_x     = calcX_q;
    assign calc_y     = calcY_q;
    assign calc_z     = calcZ_q;
    assign res_max    = resMax_q;
    assign res_min    = resMin_q;

`ifdef MINMAX_TIMEOUT_EN
    assign timeout_err = toErr_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_min_max_operand_sequencer.sv
// ---------------------------------------------------------------------------
// tb_min_max_operand_sequencer
//
// Scoreboard bench for min_max_operand_sequencer. Directed operand triples
// push their hand-computed max/min into a queue; a monitor pops and compares
// on every res_valid&res_ready handshake. A small behavioural calculator
// answers calc_start with calc_done after a fixed delay and drops it on ack.
// ---------------------------------------------------------------------------
module tb_min_max_operand_sequencer;

    localparam int WIDTH = 3;

    logic             clk;
    logic             reset_n;
    logic [WIDTH-1:0] op_data;
    logic             op_valid;
    logic             op_ready;
    logic [WIDTH-1:0] res_max;
    logic [WIDTH-1:0] res_min;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] calc_x;
    logic [WIDTH-1:0] calc_y;
    logic [WIDTH-1:0] calc_z;
    logic             calc_start;
    logic             calc_ack;
    logic             calc_done;
    logic [WIDTH-1:0] calc_max;
    logic [WIDTH-1:0] calc_min;
    logic             busy;
    logic             timeout_err;

    int checkCount = 0;
    int errorCount = 0;
    int startCount = 0;
    int ackCount   = 0;

    logic [2*WIDTH-1:0] expQ[$];

    logic       calcDoneEnable = 1'b1;
    logic [2:0] calcCnt;

    min_max_operand_sequencer #(
        .WIDTH         (WIDTH),
        .TIMEOUT_CYCLES(15)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op_data    (op_data),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .res_max    (res_max),
        .res_min    (res_min),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .calc_x     (calc_x),
        .calc_y     (calc_y),
        .calc_z     (calc_z),
        .calc_start (calc_start),
        .calc_ack   (calc_ack),
        .calc_done  (calc_done),
        .calc_max   (calc_max),
        .calc_min   (calc_min),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural calculator: raises done four cycles after seeing start and
    // keeps it high until the ack pulse, like the real level-sensitive HLSM.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            calcCnt   <= 3'd0;
            calc_done <= 1'b0;
            calc_max  <= '0;
            calc_min  <= '0;
        end else begin
            if (calc_ack) begin
                calc_done <= 1'b0;
            end
            if (calc_start) begin
                calcCnt <= 3'd4;
            end else if (calcCnt != 3'd0) begin
                calcCnt <= calcCnt - 3'd1;
                if (calcCnt == 3'd1 && calcDoneEnable) begin
                    calc_done <= 1'b1;
                    calc_max  <= (calc_x >= calc_y && calc_x >= calc_z) ? calc_x :
                                 (calc_y >= calc_z) ? calc_y : calc_z;
                    calc_min  <= (calc_x <= calc_y && calc_x <= calc_z) ? calc_x :
                                 (calc_y <= calc_z) ? calc_y : calc_z;
                end
            end
        end
    end

    // Single comparison point; every check flows through here.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, required %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: pulse counters plus scoreboard pop on each result handshake.
    always @(negedge clk) begin
        logic [2*WIDTH-1:0] exp;
        if (calc_start) startCount++;
        if (calc_ack)   ackCount++;
        if (res_valid && res_ready) begin
            if (expQ.size() == 0) begin
                checkCount++;
                errorCount++;
                $display("[TB] FAIL unexpected_result: got max=%0d min=%0d, required no result",
                         res_max, res_min);
            end else begin
                exp = expQ.pop_front();
                checkOutput("res_max", 32'(res_max), 32'(exp[2*WIDTH-1:WIDTH]));
                checkOutput("res_min", 32'(res_min), 32'(exp[WIDTH-1:0]));
            end
        end
    end

    // Present one operand after an optional op_valid gap; returns just after
    // the accepting edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] d, input int gap);
        bit ok;
        op_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            checkOutput("op_ready_gap", 32'(op_ready), 32'd1);
            @(posedge clk);
            #1;
        end
        op_valid = 1'b1;
        op_data  = d;
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (op_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        op_valid = 1'b0;
        if (!ok) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL accept_timeout: got op_ready=0, required 1");
        end
    endtask

    task automatic sendTriple(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                              input logic [WIDTH-1:0] z, input int gap);
        applyStimulus(x, gap);
        applyStimulus(y, gap);
        applyStimulus(z, gap);
        checkOutput("calc_x", 32'(calc_x), 32'(x));
        checkOutput("calc_y", 32'(calc_y), 32'(y));
        checkOutput("calc_z", 32'(calc_z), 32'(z));
        checkOutput("busy_after_load", 32'(busy), 32'd1);
        checkOutput("op_ready_after_load", 32'(op_ready), 32'd0);
    endtask

    // Wait until the DUT is back in LOAD with all expected results consumed.
    task automatic waitIdle();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge clk);
            if (op_ready && expQ.size() == 0) ok = 1'b1;
        end
        if (!ok) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL idle_timeout: got %0d pending results, required 0", expQ.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_op_ready"},   32'(op_ready),    32'd1);
        checkOutput({tag, "_busy"},       32'(busy),        32'd0);
        checkOutput({tag, "_calc_start"}, 32'(calc_start),  32'd0);
        checkOutput({tag, "_calc_ack"},   32'(calc_ack),    32'd0);
        checkOutput({tag, "_res_valid"},  32'(res_valid),   32'd0);
        checkOutput({tag, "_calc_x"},     32'(calc_x),      32'd0);
        checkOutput({tag, "_calc_y"},     32'(calc_y),      32'd0);
        checkOutput({tag, "_calc_z"},     32'(calc_z),      32'd0);
        checkOutput({tag, "_res_max"},    32'(res_max),     32'd0);
        checkOutput({tag, "_res_min"},    32'(res_min),     32'd0);
        checkOutput({tag, "_timeout"},    32'(timeout_err), 32'd0);
    endtask

    initial begin
        int s0;
        int a0;
        bit ok;

        reset_n   = 1'b0;
        op_valid  = 1'b0;
        op_data   = '0;
        res_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkResetState("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Continuous stream 5,2,7.
        s0 = startCount;
        a0 = ackCount;
        expQ.push_back({3'd7, 3'd2});
        sendTriple(3'd5, 3'd2, 3'd7, 0);
        waitIdle();
        checkOutput("start_pulses_572", 32'(startCount - s0), 32'd1);
        checkOutput("ack_pulses_572", 32'(ackCount - a0), 32'd1);

        // Equal operands with gaps, then distinct operands with gaps to show
        // the index holds across idle cycles.
        expQ.push_back({3'd4, 3'd4});
        sendTriple(3'd4, 3'd4, 3'd4, 2);
        waitIdle();
        expQ.push_back({3'd6, 3'd0});
        sendTriple(3'd3, 3'd0, 3'd6, 3);
        waitIdle();

        // Back-pressure: res_ready low for 10 cycles in RESULT.
        res_ready = 1'b0;
        s0 = startCount;
        expQ.push_back({3'd7, 3'd1});
        sendTriple(3'd1, 3'd7, 3'd4, 0);
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (res_valid) ok = 1'b1;
        end
        checkOutput("res_valid_rise", 32'(ok), 32'd1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput("hold_res_valid", 32'(res_valid), 32'd1);
            checkOutput("hold_res_max", 32'(res_max), 32'd7);
            checkOutput("hold_res_min", 32'(res_min), 32'd1);
            checkOutput("hold_op_ready", 32'(op_ready), 32'd0);
        end
        checkOutput("hold_start_pulses", 32'(startCount - s0), 32'd1);
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        waitIdle();
        @(negedge clk);
        checkOutput("res_valid_after_accept", 32'(res_valid), 32'd0);
        @(posedge clk);
        #1;

        // Reset in the middle of WAIT_DONE; the aborted triple yields nothing.
        sendTriple(3'd2, 3'd3, 3'd1, 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("busy_in_wait", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        checkResetState("midreset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        expQ.push_back({3'd6, 3'd1});
        sendTriple(3'd1, 3'd6, 3'd3, 0);
        waitIdle();

        // op_valid asserted during START/WAIT_DONE must be ignored.
        expQ.push_back({3'd5, 3'd1});
        sendTriple(3'd5, 3'd1, 3'd3, 0);
        op_valid = 1'b1;
        op_data  = 3'd7;
        repeat (4) @(posedge clk);
        #1;
        op_valid = 1'b0;
        checkOutput("ignore_calc_x", 32'(calc_x), 32'd5);
        checkOutput("ignore_calc_y", 32'(calc_y), 32'd1);
        checkOutput("ignore_calc_z", 32'(calc_z), 32'd3);
        waitIdle();

`ifdef MINMAX_TIMEOUT_EN
        // Calculator never finishes: watchdog acks once and returns to LOAD.
        calcDoneEnable = 1'b0;
        a0 = ackCount;
        sendTriple(3'd2, 3'd5, 3'd1, 0);
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (timeout_err) ok = 1'b1;
        end
        checkOutput("timeout_set", 32'(ok), 32'd1);
        repeat (3) @(negedge clk);
        checkOutput("timeout_ack_pulses", 32'(ackCount - a0), 32'd1);
        checkOutput("timeout_back_to_load", 32'(op_ready), 32'd1);
        checkOutput("timeout_sticky", 32'(timeout_err), 32'd1);
        calcDoneEnable = 1'b1;
        expQ.push_back({3'd6, 3'd2});
        applyStimulus(3'd6, 0);
        checkOutput("timeout_cleared", 32'(timeout_err), 32'd0);
        applyStimulus(3'd2, 0);
        applyStimulus(3'd4, 0);
        waitIdle();
`else
        checkOutput("timeout_tied_low", 32'(timeout_err), 32'd0);
`endif

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no completion, required completion");
        errorCount++;
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
